// File: rtl/ahb_ssram_bridge_if.sv
// AHB-Lite slave-side bus bundle for ahb_ssram_bridge.
//   slave  modport: the bridge (samples address/control/write data, drives response).
//   master modport: the interconnect or testbench side.
// Signals: HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY (to slave);
//          HRDATA, HREADYOUT, HRESP (from slave).
interface ahb_ssram_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_ssram_bridge.sv
// AHB-Lite slave front-end for a single-port synchronous SSRAM (1-cycle read latency,
// write-first, byte write enables).
// Ports:
//   HCLK, HRESETn     clock, asynchronous active-low reset
//   bus               AHB-Lite slave modport (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY in,
//                     HRDATA/HREADYOUT/HRESP out)
//   ram_en, ram_we    RAM access enable and per-byte write enables
//   ram_addr, ram_di  RAM word address and write data
//   ram_dout          RAM read data, valid the cycle after a read access
module ahb_ssram_bridge #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_ssram_bridge_if.slave     bus,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_di,
  input  logic [31:0]           ram_dout
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWr     = 3'd1;
  localparam logic [2:0] StRd     = 3'd2;
  localparam logic [2:0] StRdWait = 3'd3;
  localparam logic [2:0] StErr1   = 3'd4;
  localparam logic [2:0] StErr2   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;

  logic                  xfer;
  logic                  size_err;
  logic [3:0]            mask;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic                  can_accept;
  logic                  hreadyout;
  logic                  hresp;

  // Upper address bits wrap; HTRANS[0] (SEQ vs NONSEQ) does not change behaviour.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

  assign xfer       = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign haddr_word = bus.HADDR[ADDR_WIDTH+1:2];

  always_comb begin
    size_err = 1'b0;
    mask     = 4'b1111;
    unique case (bus.HSIZE)
      3'd0: mask = 4'b0001 << bus.HADDR[1:0];
      3'd1: begin
        mask     = 4'b0011 << {bus.HADDR[1], 1'b0};
        size_err = bus.HADDR[0];
      end
      3'd2: size_err = (bus.HADDR[1:0] != 2'b00);
      default: size_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = addr_q;
    ram_di     = bus.HWDATA;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    can_accept = 1'b0;

    case (state_q)
      StIdle, StRd: can_accept = 1'b1;
      StWr: begin
        // Data phase of the registered write owns the RAM port this cycle.
        ram_en     = 1'b1;
        ram_we     = mask_q;
        can_accept = 1'b1;
      end
      StRdWait: begin
        ram_en    = 1'b1;
        hreadyout = 1'b0;
        state_d   = StRd;
      end
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = StErr2;
      end
      StErr2: begin
        hresp      = 1'b1;
        can_accept = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (can_accept) begin
      state_d = StIdle;
      if (xfer) begin
        if (size_err) begin
          state_d = StErr1;
        end else if (bus.HWRITE) begin
          state_d = StWr;
          addr_d  = haddr_word;
          mask_d  = mask;
        end else if (state_q == StWr) begin
          // Port busy with the write: defer the read by one cycle.
          state_d = StRdWait;
          addr_d  = haddr_word;
        end else begin
          ram_en   = 1'b1;
          ram_addr = haddr_word;
          state_d  = StRd;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.HRDATA    = ram_dout;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;

endmodule
